// File: rtl/fir_pkg.sv
// Shared helpers for the time-multiplexed FIR: width derivation and the MAC
// sequencer state encoding.
package fir_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } fir_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int ch_width(input int channels);
        return (clog2(channels) > 1) ? clog2(channels) : 1;
    endfunction

    function automatic int addr_width(input int n);
        return (clog2(n) > 1) ? clog2(n) : 1;
    endfunction

    // Product width plus growth for N terms: the sum can never overflow.
    function automatic int acc_width(input int dw, input int cw, input int n);
        return dw + cw + clog2(n);
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational output scaler: round half up, arithmetic shift, clip to the
// output range and flag when clipping happened.
module fir_round_sat #(
    parameter int ACC_W     = 35,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 15
) (
    input  logic signed [ACC_W-1:0]     acc,
    output logic signed [OUT_WIDTH-1:0] res,
    output logic                        sat
);

    localparam int EW = ACC_W + 1;
    localparam logic signed [EW-1:0] MAX_V = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_V = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    // Half an output LSB; collapses to zero when SHIFT is 0 so no rounding is applied.
    localparam logic signed [EW-1:0] HALF  = (EW'(1) << SHIFT) >> 1;

    logic signed [EW-1:0] r;

    function automatic logic signed [EW-1:0] round_shift(input logic signed [EW-1:0] a);
        return (a + HALF) >>> SHIFT;
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [EW-1:0] v);
        if (v > MAX_V) return MAX_V[OUT_WIDTH-1:0];
        if (v < MIN_V) return MIN_V[OUT_WIDTH-1:0];
        return v[OUT_WIDTH-1:0];
    endfunction

    always_comb begin
        r   = round_shift({acc[ACC_W-1], acc});
        sat = (r > MAX_V) || (r < MIN_V);
        res = saturate(r);
    end

endmodule

// File: rtl/fir_tdm_mac.sv
// Multi-channel FIR sharing one multiply-accumulate unit: one accepted sample
// is filtered over N MAC cycles, then rounded/saturated and presented for one cycle.
module fir_tdm_mac
    import fir_pkg::*;
#(
    parameter int N           = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int CHANNELS    = 2,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT       = 15,
    localparam int CH_W       = ch_width(CHANNELS),
    localparam int AW         = addr_width(N)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [DATA_WIDTH-1:0]  sample_in,
    input  logic [CH_W-1:0]               ch_in,
    input  logic                          valid_in,
    output logic                          ready_in,
    input  logic                          coef_we,
    input  logic [AW-1:0]                 coef_addr,
    input  logic signed [COEFF_WIDTH-1:0] coef_data,
    output logic                          coef_err,
    output logic signed [OUT_WIDTH-1:0]   sample_out,
    output logic [CH_W-1:0]               ch_out,
    output logic                          valid_out,
    output logic                          sat_out
);

    localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
    localparam int ACC_W  = acc_width(DATA_WIDTH, COEFF_WIDTH, N);

    fir_state_t state, state_nxt;
    logic accept, coef_ok, ch_ok, addr_ok, last_tap;

    logic [AW-1:0]                 k;
    logic [AW-1:0]                 newest;
    logic [AW-1:0]                 tap_idx;
    logic [CH_W-1:0]               ch_cur;
    logic [AW-1:0]                 wptr [CHANNELS];
    logic signed [COEFF_WIDTH-1:0] coef [N];
    logic signed [DATA_WIDTH-1:0]  hist [CHANNELS][N];
    logic signed [PROD_W-1:0]      prod;
    logic signed [ACC_W-1:0]       acc;
    logic signed [OUT_WIDTH-1:0]   rs_res;
    logic                          rs_sat;

    assign ch_ok    = int'(ch_in) < CHANNELS;
    assign addr_ok  = int'(coef_addr) < N;
    assign last_tap = (k == AW'(N - 1));

    always_comb begin
        state_nxt = state;
        ready_in  = 1'b0;
        accept    = 1'b0;
        coef_ok   = 1'b0;
        case (state)
            S_IDLE: begin
                ready_in = 1'b1;
                // An out-of-range channel still completes the handshake but starts nothing.
                accept   = valid_in && ch_ok;
                coef_ok  = coef_we && !valid_in && addr_ok;
                if (accept) state_nxt = S_MAC;
            end
            S_MAC:   if (last_tap) state_nxt = S_OUT;
            S_OUT:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Tap k reads the sample k positions older than the newest one, wrapping mod N.
    always_comb begin
        if (k > newest) tap_idx = AW'(int'(newest) + N - int'(k));
        else            tap_idx = newest - k;
    end

    assign prod = coef[k] * hist[ch_cur][tap_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out  <= 1'b0;
            coef_err   <= 1'b0;
            sat_out    <= 1'b0;
            sample_out <= '0;
            ch_out     <= '0;
            k          <= '0;
            for (int t = 0; t < N; t++) coef[t] <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                wptr[c] <= '0;
                for (int t = 0; t < N; t++) hist[c][t] <= '0;
            end
        end else begin
            valid_out <= 1'b0;
            coef_err  <= coef_we && !coef_ok;
            if (coef_ok) coef[coef_addr] <= coef_data;
            if (accept) begin
                hist[ch_in][wptr[ch_in]] <= sample_in;
                wptr[ch_in] <= (wptr[ch_in] == AW'(N - 1)) ? '0 : wptr[ch_in] + 1'b1;
                k <= '0;
            end
            if (state == S_MAC) k <= k + 1'b1;
            if (state == S_OUT) begin
                sample_out <= rs_res;
                sat_out    <= rs_sat;
                ch_out     <= ch_cur;
                valid_out  <= 1'b1;
            end
        end
    end

    // Accept edge -> MAC: datapath registers, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            newest <= wptr[ch_in];
            ch_cur <= ch_in;
            acc    <= '0;
        end else if (state == S_MAC) begin
            acc <= acc + ACC_W'(prod);
        end
    end

    // MAC -> OUT: scaling stage, registered above in the OUT state.
    fir_round_sat #(
        .ACC_W     (ACC_W),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_round_sat (
        .acc (acc),
        .res (rs_res),
        .sat (rs_sat)
    );

endmodule
